ysyx_24110015_idu: RTL and testbench
====================================

# ysyx_24110015_idu

Instruction decode unit for the RV32I core. It accepts a fetched instruction and PC over a valid/ready handshake and reads rs1/rs2 from the register file. It then presents a registered decode bundle to the execute stage: ALU opcode, both ALU operands, and writeback and memory controls. It is the producer side of the ALU interface and generates every `ALU_*` opcode and operand pair the ALU consumes.

## Interface
- `DATA_WIDTH`, 32, datapath width of PC, instruction, operands and immediate.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: drop the held bundle and block capture this cycle.
- `in_valid` in 1: instruction available.
- `in_ready` out 1: IDU accepts the instruction this cycle.
- `inst` in DATA_WIDTH: instruction word.
- `pc` in DATA_WIDTH: instruction PC.
- `rs1_addr`, `rs2_addr` out 5: combinational, `inst[19:15]` and `inst[24:20]`.
- `rs1_data`, `rs2_data` in DATA_WIDTH: register file read data, same cycle.
- `out_valid` out 1: decode bundle valid.
- `out_ready` in 1: execute stage accepts the bundle.
- `alu_op` out 4: `ALU_*` code.
- `alu_src1`, `alu_src2` out DATA_WIDTH: ALU operands.
- `imm` out DATA_WIDTH: sign-extended immediate.
- `target` out DATA_WIDTH: `pc + imm` for branch/JAL; for JALR, `rs1_data + imm` with bit 0 cleared.
- `link` out DATA_WIDTH: `pc + 4`.
- `rd` out 5; `wen` out 1; `wsel` out 2: 0=ALU, 1=mem, 2=link.
- `mem_ren`, `mem_wen` out 1; `mem_funct3` out 3.
- `branch`, `jump` out 1.
- `illegal` out 1.

## Operation
- Opcode encoding, from the shared macros file:
  - ADD 0000, SLL 0001, LT 0010, LTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111.
  - SUB 1000, EQ 1001, NE 1010, GE 1011, GEU 1100, SRA 1101.
  - 1110 and 1111 are never emitted.
- Operand selection:
  - LUI: src1=0, src2=imm.
  - AUIPC: src1=pc, src2=imm.
  - OP: src1=rs1, src2=rs2.
  - OP-IMM, LOAD, STORE: src1=rs1, src2=imm. For shifts, src2=`{27'b0, shamt}`.
  - BRANCH: src1=rs1, src2=rs2.
  - JAL, JALR: src1=pc, src2=4 (ALU result unused, link via `wsel`=2).
- ALU op mapping:
  - funct3 maps to the ALU op.
  - `inst[30]` selects SUB over ADD (OP only) and SRA over SRL (OP and OP-IMM).
  - Branch funct3 000/001/100/101/110/111 maps to EQ/NE/LT/GE/LTU/GEU.
  - LOAD, STORE, LUI and AUIPC use ADD.
- `wen` is 0 when `rd`==0, and 0 for STORE and BRANCH.
- Illegal instructions:
  - Conditions: unknown opcode, branch funct3 010/011, or OP with funct7 not 0000000/0100000.
  - Response: `illegal`=1, `alu_op`=ADD, and wen/mem_ren/mem_wen/branch/jump all 0.
- FENCE/SYSTEM decode as illegal.

## Timing
- The bundle is a single register stage. An accepted instruction appears on the outputs the next cycle, so latency is 1.
- `in_ready = !out_valid || out_ready`, combinational, and not dependent on `in_valid`.
- Capture happens when `in_valid && in_ready && !flush`. The bundle is loaded from `inst`, `pc` and the same-cycle `rs*_data`, and `out_valid` is set to 1.
- If `out_valid && out_ready` with no capture, `out_valid` is cleared to 0.
- Back-to-back operation: a simultaneous handoff and capture keeps `out_valid`=1 with the new bundle, sustaining 1 instruction per cycle.
- While `out_valid && !out_ready`, every bundle output is held bit-stable.
- `flush` overrides capture: `out_valid` goes to 0 next cycle and any `in_valid` in that cycle is not accepted.
- `rst` overrides `flush`. At reset, `out_valid`=0 and all bundle outputs are 0. A held bundle is discarded.

## Structure
- `ALU_*` codes, opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011) and `WSEL_*` live in the shared macros file.
- Sub-module `ysyx_24110015_immgen` (combinational): produces the I/S/B/U/J immediate from `inst`.

## Test plan
- `inst`=0x00510093 (addi x1,x2,5), rs1_data=0x10 -> next cycle: `out_valid`=1, alu_op=0000, src1=0x10, src2=5, rd=1, wen=1.
- `inst`=0x402081B3 (sub x3,x1,x2) followed immediately by 0x40335293 (srai x5,x6,3), with `out_ready`=1 -> consecutive cycles show op 1000, then op 1101 with src2=3; no bubble.
- `inst`=0x00208463 (beq x1,x2,+8), pc=0x80000000 -> alu_op=1001, branch=1, target=0x80000008, wen=0.
- `inst`=0x123450B7 (lui x1,0x12345) -> src1=0, src2=0x12345000, op=0000. With `out_ready`=0 for 3 cycles: `in_ready`=0 and outputs stable.
- `inst`=0x00000000 -> illegal=1, wen=0, mem_wen=0. A following `flush` -> `out_valid`=0 next cycle.
- `rst` asserted while `out_valid`=1 and `out_ready`=0 -> next cycle `out_valid`=0, all outputs 0, `in_ready`=1.

Source files
------------

// File: rtl/ysyx_24110015_idu_pkg.sv
// Shared decode definitions for the RV32I IDU: ALU opcodes, base opcodes,
// writeback selects and small decode helpers.
package ysyx_24110015_idu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SLL = 4'b0001,
    ALU_LT  = 4'b0010,
    ALU_LTU = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_OR  = 4'b0110,
    ALU_AND = 4'b0111,
    ALU_SUB = 4'b1000,
    ALU_EQ  = 4'b1001,
    ALU_NE  = 4'b1010,
    ALU_GE  = 4'b1011,
    ALU_GEU = 4'b1100,
    ALU_SRA = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'd0,
    WSEL_MEM  = 2'd1,
    WSEL_LINK = 2'd2
  } wsel_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate format implied by the base opcode; unknown opcodes fall back to I.
  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    imm_type_e t;
    case (opc)
      OPC_LUI, OPC_AUIPC:            t = IMM_U;
      OPC_JAL:                       t = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: t = IMM_I;
      OPC_STORE:                     t = IMM_S;
      OPC_BRANCH:                    t = IMM_B;
      OPC_OP:                        t = IMM_NONE;
      default:                       t = IMM_I;
    endcase
    return t;
  endfunction

  // Branch funct3 to comparison op; 010/011 are reserved and flagged elsewhere.
  function automatic alu_op_e branch_alu_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_EQ;
      3'b001:  op = ALU_NE;
      3'b100:  op = ALU_LT;
      3'b101:  op = ALU_GE;
      3'b110:  op = ALU_LTU;
      3'b111:  op = ALU_GEU;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_24110015_idu_immgen.sv
// Combinational immediate generator: picks the I/S/B/U/J immediate for the
// instruction's opcode and sign-extends it to the datapath width.
module ysyx_24110015_immgen
  import ysyx_24110015_idu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] imm
);

  logic signed [31:0] imm32;

  // Assemble the 32-bit immediate by format, then widen with sign.
  always_comb begin
    imm32 = '0;
    case (imm_type_of(inst[6:0]))
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = DATA_WIDTH'(imm32);
  end

endmodule

// File: rtl/ysyx_24110015_idu.sv
// RV32I instruction decode unit: decodes the fetched instruction against
// same-cycle register reads and holds the result in a single bundle register
// with a valid/ready handshake on both sides.
module ysyx_24110015_idu
  import ysyx_24110015_idu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] inst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_src1,
  output logic [DATA_WIDTH-1:0] alu_src2,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] link,
  output logic [4:0]            rd,
  output logic                  wen,
  output logic [1:0]            wsel,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [2:0]            mem_funct3,
  output logic                  branch,
  output logic                  jump,
  output logic                  illegal
);

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  logic [6:0]            opc;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [4:0]            rd_f;
  logic [DATA_WIDTH-1:0] imm_w;
  logic [DATA_WIDTH-1:0] shamt_w;
  logic [DATA_WIDTH-1:0] jalr_sum;
  logic                  capture;

  alu_op_e               d_op;
  logic [DATA_WIDTH-1:0] d_src1, d_src2, d_target;
  logic                  d_wen, d_mren, d_mwen, d_br, d_jmp, d_ill;
  wsel_e                 d_wsel;
  logic [2:0]            d_mf3;

  logic                  vld_p1;
  alu_op_e               alu_op_p1;
  logic [DATA_WIDTH-1:0] src1_p1, src2_p1, imm_p1, target_p1, link_p1;
  logic [4:0]            rd_p1;
  logic                  wen_p1, mren_p1, mwen_p1, br_p1, jmp_p1, ill_p1;
  wsel_e                 wsel_p1;
  logic [2:0]            mf3_p1;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign rd_f     = inst[11:7];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign shamt_w  = {{(DATA_WIDTH-5){1'b0}}, inst[24:20]};
  assign jalr_sum = rs1_data + imm_w;

  // The bundle register frees up as soon as it is empty or being drained.
  assign in_ready = !vld_p1 || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  ysyx_24110015_immgen #(.DATA_WIDTH(DATA_WIDTH)) u_immgen (
    .inst (inst),
    .imm  (imm_w)
  );

  // Decode: operand muxing, ALU op and side-effect controls for the instruction.
  always_comb begin
    d_op     = ALU_ADD;
    d_src1   = '0;
    d_src2   = '0;
    d_target = pc + imm_w;
    d_wen    = 1'b0;
    d_wsel   = WSEL_ALU;
    d_mren   = 1'b0;
    d_mwen   = 1'b0;
    d_mf3    = 3'b000;
    d_br     = 1'b0;
    d_jmp    = 1'b0;
    d_ill    = 1'b0;
    case (opc)
      OPC_LUI: begin
        d_src2 = imm_w;
        d_wen  = 1'b1;
      end
      OPC_AUIPC: begin
        d_src1 = pc;
        d_src2 = imm_w;
        d_wen  = 1'b1;
      end
      OPC_JAL: begin
        d_src1 = pc;
        d_src2 = FOUR;
        d_wen  = 1'b1;
        d_wsel = WSEL_LINK;
        d_jmp  = 1'b1;
      end
      OPC_JALR: begin
        d_src1   = pc;
        d_src2   = FOUR;
        d_target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
        d_wen    = 1'b1;
        d_wsel   = WSEL_LINK;
        d_jmp    = 1'b1;
      end
      OPC_BRANCH: begin
        d_src1 = rs1_data;
        d_src2 = rs2_data;
        if (f3 == 3'b010 || f3 == 3'b011) begin
          d_ill = 1'b1;
        end else begin
          d_op = branch_alu_op(f3);
          d_br = 1'b1;
        end
      end
      OPC_LOAD: begin
        d_src1 = rs1_data;
        d_src2 = imm_w;
        d_mren = 1'b1;
        d_mf3  = f3;
        d_wen  = 1'b1;
        d_wsel = WSEL_MEM;
      end
      OPC_STORE: begin
        d_src1 = rs1_data;
        d_src2 = imm_w;
        d_mwen = 1'b1;
        d_mf3  = f3;
      end
      OPC_OP_IMM: begin
        d_src1 = rs1_data;
        d_src2 = (f3 == 3'b001 || f3 == 3'b101) ? shamt_w : imm_w;
        d_op   = (f3 == 3'b101 && inst[30]) ? ALU_SRA : alu_op_e'({1'b0, f3});
        d_wen  = 1'b1;
      end
      OPC_OP: begin
        d_src1 = rs1_data;
        d_src2 = rs2_data;
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          if (f3 == 3'b000 && inst[30])      d_op = ALU_SUB;
          else if (f3 == 3'b101 && inst[30]) d_op = ALU_SRA;
          else                               d_op = alu_op_e'({1'b0, f3});
          d_wen = 1'b1;
        end else begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
    if (rd_f == 5'd0) d_wen = 1'b0;
  end

  // ---- stage p1: decode bundle register ----
  // Load on capture; drop valid on handoff or flush; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      alu_op_p1 <= ALU_ADD;
      src1_p1   <= '0;
      src2_p1   <= '0;
      imm_p1    <= '0;
      target_p1 <= '0;
      link_p1   <= '0;
      rd_p1     <= '0;
      wen_p1    <= 1'b0;
      wsel_p1   <= WSEL_ALU;
      mren_p1   <= 1'b0;
      mwen_p1   <= 1'b0;
      mf3_p1    <= '0;
      br_p1     <= 1'b0;
      jmp_p1    <= 1'b0;
      ill_p1    <= 1'b0;
    end else if (capture) begin
      vld_p1    <= 1'b1;
      alu_op_p1 <= d_op;
      src1_p1   <= d_src1;
      src2_p1   <= d_src2;
      imm_p1    <= imm_w;
      target_p1 <= d_target;
      link_p1   <= pc + FOUR;
      rd_p1     <= rd_f;
      wen_p1    <= d_wen;
      wsel_p1   <= d_wsel;
      mren_p1   <= d_mren;
      mwen_p1   <= d_mwen;
      mf3_p1    <= d_mf3;
      br_p1     <= d_br;
      jmp_p1    <= d_jmp;
      ill_p1    <= d_ill;
    end else if (flush || out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign alu_op     = alu_op_p1;
  assign alu_src1   = src1_p1;
  assign alu_src2   = src2_p1;
  assign imm        = imm_p1;
  assign target     = target_p1;
  assign link       = link_p1;
  assign rd         = rd_p1;
  assign wen        = wen_p1;
  assign wsel       = wsel_p1;
  assign mem_ren    = mren_p1;
  assign mem_wen    = mwen_p1;
  assign mem_funct3 = mf3_p1;
  assign branch     = br_p1;
  assign jump       = jmp_p1;
  assign illegal    = ill_p1;

endmodule

// File: tb/tb_ysyx_24110015_idu.sv
// Scoreboard bench for the IDU: stimulus pushes hand-computed bundles, a
// monitor pops and compares on every out_valid && out_ready handoff.
module tb_ysyx_24110015_idu;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1, s2, imm, tgt, lnk;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  wsel;
    logic        mren, mwen;
    logic [2:0]  mf3;
    logic        br, jmp, ill;
    bit          chk_ops;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [3:0]  alu_op;
  logic [31:0] alu_src1, alu_src2, imm, target, link;
  logic        wen, mem_ren, mem_wen, branch, jump, illegal;
  logic [1:0]  wsel;
  logic [2:0]  mem_funct3;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  ysyx_24110015_idu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .imm(imm), .target(target), .link(link),
    .rd(rd), .wen(wen), .wsel(wsel),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_funct3(mem_funct3),
    .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] s1, s2, im, tg, lk,
                              input logic [4:0] r, input logic w, input logic [1:0] ws,
                              input logic mr, mw, input logic [2:0] f3,
                              input logic b, j, il, input bit co);
    exp_t e;
    e.op = op; e.s1 = s1; e.s2 = s2; e.imm = im; e.tgt = tg; e.lnk = lk;
    e.rd = r; e.wen = w; e.wsel = ws; e.mren = mr; e.mwen = mw; e.mf3 = f3;
    e.br = b; e.jmp = j; e.ill = il; e.chk_ops = co;
    return e;
  endfunction

  task automatic send(input logic [31:0] i, p, a, b, input exp_t e, input bit push,
                      output int waited);
    in_valid = 1'b1; inst = i; pc = p; rs1_data = a; rs2_data = b;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("accept", 32'(in_ready), 32'd1);
    if (in_ready && push) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare the presented bundle at every handoff.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_bundle", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("alu_op",  32'(alu_op),     32'(e.op));
          chk("link",    link,            e.lnk);
          chk("rd",      32'(rd),         32'(e.rd));
          chk("wen",     32'(wen),        32'(e.wen));
          chk("wsel",    32'(wsel),       32'(e.wsel));
          chk("mem_ren", 32'(mem_ren),    32'(e.mren));
          chk("mem_wen", 32'(mem_wen),    32'(e.mwen));
          chk("mem_f3",  32'(mem_funct3), 32'(e.mf3));
          chk("branch",  32'(branch),     32'(e.br));
          chk("jump",    32'(jump),       32'(e.jmp));
          chk("illegal", 32'(illegal),    32'(e.ill));
          if (e.chk_ops) begin
            chk("src1",   alu_src1, e.s1);
            chk("src2",   alu_src2, e.s2);
            chk("imm",    imm,      e.imm);
            chk("target", target,   e.tgt);
          end
        end
      end
    end
  end

  initial begin
    int w;
    exp_t none;
    none = mk(4'h0, 0, 0, 0, 0, 0, 5'd0, 0, 2'd0, 0, 0, 3'd0, 0, 0, 0, 0);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_link",      link,           32'd0);
    @(posedge clk); #1;

    // addi x1,x2,5
    inst = 32'h00510093; #1;
    chk("rs1_addr", 32'(rs1_addr), 32'd2);
    chk("rs2_addr", 32'(rs2_addr), 32'd5);
    send(32'h00510093, 32'h100, 32'h10, 32'h0,
         mk(4'h0, 32'h10, 32'h5, 32'h5, 32'h105, 32'h104, 5'd1, 1, 2'd0, 0, 0, 3'd0, 0, 0, 0, 1), 1, w);
    // sub x3,x1,x2 then srai x5,x6,3 back to back
    send(32'h402081B3, 32'h200, 32'h30, 32'h10,
         mk(4'h8, 32'h30, 32'h10, 32'h0, 32'h200, 32'h204, 5'd3, 1, 2'd0, 0, 0, 3'd0, 0, 0, 0, 1), 1, w);
    send(32'h40335293, 32'h204, 32'hF0, 32'h0,
         mk(4'hD, 32'hF0, 32'h3, 32'h403, 32'h607, 32'h208, 5'd5, 1, 2'd0, 0, 0, 3'd0, 0, 0, 0, 1), 1, w);
    chk("no_bubble_wait", 32'(w), 32'd0);
    // beq x1,x2,+8
    send(32'h00208463, 32'h80000000, 32'h5, 32'h5,
         mk(4'h9, 32'h5, 32'h5, 32'h8, 32'h80000008, 32'h80000004, 5'd8, 0, 2'd0, 0, 0, 3'd0, 1, 0, 0, 1), 1, w);
    // jalr x1,3(x2): target bit 0 cleared
    send(32'h003100E7, 32'h500, 32'h1000, 32'h0,
         mk(4'h0, 32'h500, 32'h4, 32'h3, 32'h1002, 32'h504, 5'd1, 1, 2'd2, 0, 0, 3'd0, 0, 1, 0, 1), 1, w);
    // sw x2,8(x1)
    send(32'h0020A423, 32'h600, 32'h2000, 32'hDEAD,
         mk(4'h0, 32'h2000, 32'h8, 32'h8, 32'h608, 32'h604, 5'd8, 0, 2'd0, 0, 1, 3'd2, 0, 0, 0, 1), 1, w);
    // addi x0,x0,0: rd==0 suppresses wen
    send(32'h00000013, 32'h700, 32'h77, 32'h0,
         mk(4'h0, 32'h77, 32'h0, 32'h0, 32'h700, 32'h704, 5'd0, 0, 2'd0, 0, 0, 3'd0, 0, 0, 0, 1), 1, w);
    // mul x1,x2,x3: bad funct7 is illegal
    send(32'h023100B3, 32'h800, 32'h1, 32'h2,
         mk(4'h0, 0, 0, 0, 0, 32'h804, 5'd1, 0, 2'd0, 0, 0, 3'd0, 0, 0, 1, 0), 1, w);
    repeat (2) @(posedge clk);
    #1;

    // lui x1,0x12345 held under back-pressure
    out_ready = 1'b0;
    send(32'h123450B7, 32'h300, 32'h0, 32'h0,
         mk(4'h0, 32'h0, 32'h12345000, 32'h12345000, 32'h12345300, 32'h304, 5'd1, 1, 2'd0, 0, 0, 3'd0, 0, 0, 0, 1), 1, w);
    in_valid = 1'b1; inst = 32'h0; pc = 32'h400; rs1_data = 0; rs2_data = 0;
    q.push_back(mk(4'h0, 0, 0, 0, 0, 32'h404, 5'd0, 0, 2'd0, 0, 0, 3'd0, 0, 0, 1, 0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_src2",      alu_src2,       32'h12345000);
      chk("stall_target",    target,         32'h12345300);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    // flush while an instruction is offered: not accepted, valid drops
    flush = 1'b1; inst = 32'h00510093; pc = 32'h900;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // reset while a bundle is held
    out_ready = 1'b0;
    send(32'h00510093, 32'h100, 32'h10, 32'h0, none, 0, w);
    @(negedge clk);
    chk("held_before_rst", 32'(out_valid), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_src1",      alu_src1,       32'd0);
    chk("rst_src2",      alu_src2,       32'd0);
    chk("rst_imm",       imm,            32'd0);
    chk("rst_link",      link,           32'd0);
    chk("rst_rd_wen",    32'({rd, wen}), 32'd0);
    out_ready = 1'b1;

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
